// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared types and widths for the data memory responder.
package data_mem_pkg;
    localparam int BYTE_LANES = 4;
    localparam int WORD_W = 32;
    typedef enum logic {CLEAR, READY} state_t;
endpackage

// File: rtl/dmem_byte_merge.sv
// dmem_byte_merge: per-lane select of new bytes over an old word under byte strobes.
module dmem_byte_merge
    import data_mem_pkg::*;
(
    input  logic [WORD_W-1:0]     old_word,
    input  logic [WORD_W-1:0]     new_word,
    input  logic [BYTE_LANES-1:0] strobe,
    output logic [WORD_W-1:0]     merged
);
    for (genvar i = 0; i < BYTE_LANES; i++) begin : g_lane
        assign merged[8*i +: 8] = strobe[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
endmodule

// File: rtl/data_mem_resp.sv
// data_mem_resp: byte-strobed data memory that zero-fills itself after reset.
// Define DMEM_WR_FWD_EN to return the merged post-write word on a same-cycle read+write.
module data_mem_resp
    import data_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_read,
    input  logic [BYTE_LANES-1:0] data_write,
    input  logic [31:0]           data_addr,
    input  logic [WORD_W-1:0]     data_in,
    output logic [WORD_W-1:0]     data_out,
    output logic                  busy,
    output logic                  err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    state_t state, state_d;
    logic [AW-1:0] idx, idx_d, widx;
    logic [WORD_W-1:0] mem [DEPTH_WORDS];
    logic [WORD_W-1:0] old_word, merged, rd_word;
    logic ready, in_range, unused_addr_bits;
    assign ready = state == READY;
    assign busy = !ready;
    assign widx = data_addr[AW+1:2];
    assign in_range = data_addr[31:AW+2] == '0;
    assign old_word = mem[widx];
    assign unused_addr_bits = ^data_addr[1:0];
    dmem_byte_merge u_merge (
        .old_word(old_word),
        .new_word(data_in),
        .strobe  (data_write),
        .merged  (merged)
    );
`ifdef DMEM_WR_FWD_EN
    assign rd_word = |data_write ? merged : old_word;
`else
    assign rd_word = old_word;
`endif
    always_comb begin
        state_d = (state == CLEAR && idx == AW'(DEPTH_WORDS - 1)) ? READY : state;
        idx_d = busy ? idx + 1'b1 : idx;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= CLEAR;
            idx      <= '0;
            data_out <= '0;
            err      <= 1'b0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
            if (ready && data_read)
                data_out <= in_range ? rd_word : '0;
            err <= ready && !in_range && (data_read || |data_write);
        end
    end
    // Single write port shared by the clear sweep and CPU writes.
    always_ff @(posedge clk) begin
        if (busy || (in_range && |data_write))
            mem[busy ? idx : widx] <= busy ? '0 : merged;
    end
endmodule

// File: tb/tb_data_mem_resp.sv
// tb_data_mem_resp: scoreboard bench for data_mem_resp with DEPTH_WORDS=16.
module tb_data_mem_resp;
    localparam int DEPTH = 16;
`ifdef DMEM_WR_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    typedef struct {
        logic [31:0] dout;
        logic        err;
        logic        busy;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        data_read = 1'b0;
    logic [3:0]  data_write = '0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic        busy, err;

    data_mem_resp #(.DEPTH_WORDS(DEPTH)) dut (
        .clk(clk), .rst(rst), .data_read(data_read), .data_write(data_write),
        .data_addr(data_addr), .data_in(data_in), .data_out(data_out),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] mem_m [DEPTH];
    logic [31:0] dout_m = '0;
    logic        err_m = 1'b0;
    int          clr_left = DEPTH;

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks += 3;
                if (data_out !== e.dout) begin
                    n_fail++;
                    $display("FAIL data_out at %0t: got %h expected %h", $time, data_out, e.dout);
                end
                if (err !== e.err) begin
                    n_fail++;
                    $display("FAIL err at %0t: got %b expected %b", $time, err, e.err);
                end
                if (busy !== e.busy) begin
                    n_fail++;
                    $display("FAIL busy at %0t: got %b expected %b", $time, busy, e.busy);
                end
            end
        end
    end

    task automatic step(input logic rd, input logic [3:0] wr, input logic [31:0] a, input logic [31:0] d);
        int w;
        logic in_r;
        logic [31:0] pre;
        @(negedge clk);
        data_read = rd;
        data_write = wr;
        data_addr = a;
        data_in = d;
        if (clr_left > 0) begin
            clr_left--;
            err_m = 1'b0;
        end else begin
            w = int'(a[5:2]);
            in_r = a < 32'(4 * DEPTH);
            pre = mem_m[w];
            if (in_r)
                for (int b = 0; b < 4; b++)
                    if (wr[b]) mem_m[w][8*b +: 8] = d[8*b +: 8];
            if (rd) dout_m = !in_r ? 32'h0 : (FWD ? mem_m[w] : pre);
            err_m = !in_r && (rd || wr != 4'h0);
        end
        sb.push_back('{dout_m, err_m, clr_left > 0});
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = 1'b0;
            data_read = 1'b0;
            data_write = '0;
            dout_m = '0;
            err_m = 1'b0;
            sb.push_back('{32'h0, 1'b0, 1'b1});
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        clr_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    endtask

    initial begin
        int r;
        logic [31:0] a;
        do_reset(3);
        step(1'b1, 4'hF, 32'h0, 32'hFFFFFFFF);
        step(1'b1, 4'h0, 32'h0, 32'h0);
        repeat (DEPTH - 2) step(1'b0, 4'h0, 32'h0, 32'h0);
        step(1'b1, 4'h0, 32'h3C, 32'h0);
        step(1'b1, 4'h0, 32'h0, 32'h0);
        step(1'b0, 4'hF, 32'h10, 32'hDEADBEEF);
        step(1'b0, 4'h1, 32'h10, 32'h000000AA);
        step(1'b1, 4'h0, 32'h10, 32'h0);
        step(1'b0, 4'h0, 32'h0, 32'h0);
        step(1'b1, 4'hC, 32'h20, 32'h12345678);
        step(1'b0, 4'h0, 32'h0, 32'h0);
        step(1'b1, 4'h0, 32'h22, 32'h0);
        step(1'b0, 4'hF, 32'h0, 32'h0BADF00D);
        step(1'b1, 4'h0, 32'h40, 32'h0);
        step(1'b0, 4'h0, 32'h0, 32'h0);
        step(1'b0, 4'hF, 32'h40, 32'hFFFFFFFF);
        step(1'b0, 4'h0, 32'h0, 32'h0);
        for (int w = 0; w < DEPTH; w++) step(1'b1, 4'h0, 32'(4 * w), 32'h0);
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            a = r == 0 ? 32'($urandom) : (r == 1 ? 32'h40 + 32'($urandom_range(0, 63)) : 32'($urandom_range(0, 63)));
            step(1'($urandom_range(0, 1)), 4'($urandom), a, 32'($urandom));
        end
        do_reset(2);
        repeat (7) step(1'b1, 4'hF, 32'h8, 32'h55555555);
        do_reset(2);
        repeat (DEPTH + 2) step(1'b0, 4'h0, 32'h0, 32'h0);
        step(1'b1, 4'h0, 32'h8, 32'h0);
        step(1'b0, 4'h0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #3;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
